// File: rtl/sargantana_icache_pkg.sv
// Shared types and default geometry for the icache miss-fill engine.
package sargantana_icache_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    DROP = 3'd3,
    RESP = 3'd4
  } ifill_state_t;

  localparam int DEF_BEAT_W = 128;
  localparam int DEF_LINE_W = 512;
  localparam int N_BEATS    = DEF_LINE_W / DEF_BEAT_W;
  localparam int BEAT_CNT_W = $clog2(N_BEATS);
  localparam int LINE_OFF_W = $clog2(DEF_LINE_W / 8);

endpackage

// File: rtl/sargantana_icache_way_rr.sv
// Round-robin one-hot victim way pointer; advances by one way per completed fill.
module sargantana_icache_way_rr #(
  parameter int N_WAY = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             advance_i,
  output logic [N_WAY-1:0] way_o
);

  // Rotate the one-hot pointer left on each advance, wrapping the top way back to way 0
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      way_o <= {{(N_WAY-1){1'b0}}, 1'b1};
    end else if (advance_i) begin
      way_o <= {way_o[N_WAY-2:0], way_o[N_WAY-1]};
    end else begin
      way_o <= way_o;
    end
  end

endmodule

// File: rtl/sargantana_icache_ifill.sv
// Icache miss-fill engine: issues a line read to L2, assembles beats, returns the line with its victim way.
// Optional watchdog enabled by defining ICACHE_IFILL_TIMEOUT_EN.
module sargantana_icache_ifill
  import sargantana_icache_pkg::*;
#(
  parameter int ICACHE_N_WAY = 4,
  parameter int PADDR_W      = 40,
  parameter int BEAT_W       = 128,
  parameter int LINE_W       = 512,
  parameter int TIMEOUT_CYC  = 1024
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    ifill_req_valid_i,
  input  logic [PADDR_W-1:0]      ifill_paddr_i,
  input  logic                    kill_i,
  output logic                    ifill_sent_ack_o,
  output logic                    ifill_resp_valid_o,
  output logic                    valid_ifill_resp_o,
  output logic [LINE_W-1:0]       ifill_line_o,
  output logic [ICACHE_N_WAY-1:0] ifill_way_o,
  output logic [PADDR_W-1:0]      ifill_addr_o,
  output logic                    l2_req_valid_o,
  input  logic                    l2_req_ready_i,
  output logic [PADDR_W-1:0]      l2_req_paddr_o,
  input  logic                    l2_resp_valid_i,
  input  logic [BEAT_W-1:0]       l2_resp_data_i,
  output logic                    ifill_timeout_o
);

  localparam int NB    = LINE_W / BEAT_W;
  localparam int CNT_W = $clog2(NB);
  localparam int OFF_W = $clog2(LINE_W / 8);

  ifill_state_t            state_r;
  logic [CNT_W-1:0]        beat_cnt_r;
  logic                    killed_r;
  logic                    last_beat_s;
  logic                    way_adv_s;
  logic                    timeout_s;
  logic [ICACHE_N_WAY-1:0] way_ptr_s;
  logic [PADDR_W-1:0]      aligned_paddr_s;

  assign aligned_paddr_s = {ifill_paddr_i[PADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign last_beat_s     = l2_resp_valid_i && (beat_cnt_r == CNT_W'(NB - 1));
  assign way_adv_s       = (state_r == RESP);

  sargantana_icache_way_rr #(
    .N_WAY (ICACHE_N_WAY)
  ) u_way_rr (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .advance_i (way_adv_s),
    .way_o     (way_ptr_s)
  );

`ifdef ICACHE_IFILL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt_r;
  logic            waiting_s;

  assign waiting_s = (state_r == WAIT) || (state_r == DROP);
  assign timeout_s = waiting_s && !l2_resp_valid_i && (to_cnt_r == TO_W'(TIMEOUT_CYC - 1));

  // Watchdog: counts silent cycles while beats are owed; restarts on each beat and on WAIT->DROP
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else if (!waiting_s || l2_resp_valid_i || timeout_s || ((state_r == WAIT) && kill_i)) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Fill sequencing together with every registered controller and L2 output
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_r            <= IDLE;
      beat_cnt_r         <= {CNT_W{1'b0}};
      killed_r           <= 1'b0;
      ifill_sent_ack_o   <= 1'b0;
      ifill_resp_valid_o <= 1'b0;
      valid_ifill_resp_o <= 1'b0;
      ifill_line_o       <= {LINE_W{1'b0}};
      ifill_way_o        <= {ICACHE_N_WAY{1'b0}};
      ifill_addr_o       <= {PADDR_W{1'b0}};
      l2_req_valid_o     <= 1'b0;
      l2_req_paddr_o     <= {PADDR_W{1'b0}};
      ifill_timeout_o    <= 1'b0;
    end else begin
      ifill_resp_valid_o <= 1'b0;
      valid_ifill_resp_o <= 1'b0;
      ifill_timeout_o    <= timeout_s;
      case (state_r)
        IDLE: begin
          killed_r   <= 1'b0;
          beat_cnt_r <= {CNT_W{1'b0}};
          if (ifill_req_valid_i) begin
            l2_req_paddr_o   <= aligned_paddr_s;
            ifill_addr_o     <= aligned_paddr_s;
            l2_req_valid_o   <= 1'b1;
            ifill_sent_ack_o <= 1'b1;
            state_r          <= REQ;
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          // A kill cannot withdraw the request; it only marks the returning data for discard
          if (kill_i) begin
            killed_r <= 1'b1;
          end else begin
            killed_r <= killed_r;
          end
          if (l2_req_ready_i) begin
            l2_req_valid_o <= 1'b0;
            state_r        <= (killed_r || kill_i) ? DROP : WAIT;
          end else begin
            state_r <= REQ;
          end
        end
        WAIT: begin
          if (timeout_s) begin
            ifill_sent_ack_o <= 1'b0;
            state_r          <= IDLE;
          end else if (l2_resp_valid_i) begin
            ifill_line_o[beat_cnt_r*BEAT_W +: BEAT_W] <= l2_resp_data_i;
            beat_cnt_r <= beat_cnt_r + CNT_W'(1);
            if (last_beat_s) begin
              ifill_sent_ack_o <= 1'b0;
              if (kill_i) begin
                state_r <= IDLE;
              end else begin
                ifill_resp_valid_o <= 1'b1;
                ifill_way_o        <= way_ptr_s;
                state_r            <= RESP;
              end
            end else if (kill_i) begin
              state_r <= DROP;
            end else begin
              state_r <= WAIT;
            end
          end else if (kill_i) begin
            state_r <= DROP;
          end else begin
            state_r <= WAIT;
          end
        end
        DROP: begin
          if (timeout_s) begin
            ifill_sent_ack_o <= 1'b0;
            state_r          <= IDLE;
          end else if (l2_resp_valid_i) begin
            beat_cnt_r <= beat_cnt_r + CNT_W'(1);
            if (last_beat_s) begin
              ifill_sent_ack_o <= 1'b0;
              state_r          <= IDLE;
            end else begin
              state_r <= DROP;
            end
          end else begin
            state_r <= DROP;
          end
        end
        RESP: begin
          valid_ifill_resp_o <= !kill_i;
          state_r            <= IDLE;
        end
        default: begin
          ifill_sent_ack_o <= 1'b0;
          l2_req_valid_o   <= 1'b0;
          state_r          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sargantana_icache_ifill.sv
// Randomized scoreboard bench for sargantana_icache_ifill (timeout scenario under ICACHE_IFILL_TIMEOUT_EN).
module tb_sargantana_icache_ifill;
  import sargantana_icache_pkg::*;

  localparam int N_WAY   = 4;
  localparam int PADDR_W = 40;
  localparam int BEAT_W  = 128;
  localparam int LINE_W  = 512;
  localparam int TO_CYC  = 16;
  localparam int NB      = N_BEATS;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                req_valid = 1'b0;
  logic [PADDR_W-1:0]  req_paddr = '0;
  logic                kill = 1'b0;
  logic                ack, strobe, vld_resp, l2_req_valid, l2_ready = 1'b0, l2_rvalid = 1'b0, tout;
  logic [LINE_W-1:0]   line;
  logic [N_WAY-1:0]    way;
  logic [PADDR_W-1:0]  faddr, l2_paddr;
  logic [BEAT_W-1:0]   l2_rdata = '0;

  sargantana_icache_ifill #(
    .ICACHE_N_WAY(N_WAY), .PADDR_W(PADDR_W), .BEAT_W(BEAT_W), .LINE_W(LINE_W), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .ifill_req_valid_i(req_valid), .ifill_paddr_i(req_paddr), .kill_i(kill),
    .ifill_sent_ack_o(ack), .ifill_resp_valid_o(strobe), .valid_ifill_resp_o(vld_resp),
    .ifill_line_o(line), .ifill_way_o(way), .ifill_addr_o(faddr),
    .l2_req_valid_o(l2_req_valid), .l2_req_ready_i(l2_ready), .l2_req_paddr_o(l2_paddr),
    .l2_resp_valid_i(l2_rvalid), .l2_resp_data_i(l2_rdata), .ifill_timeout_o(tout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LINE_W-1:0]  line;
    logic [N_WAY-1:0]   way;
    logic [PADDR_W-1:0] addr;
    bit                 vld;
    int                 lat;
    int                 req_cyc;
  } exp_t;

  exp_t               exp_q[$];
  int                 n_checks = 0;
  int                 n_pass = 0;
  int                 cyc = 0;
  int                 n_fills = 0;
  logic [PADDR_W-1:0] exp_req_addr = '0;
  bit                 mon_en = 1'b0;
  bit                 to_window = 1'b0;

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops the scoreboard on every line strobe and checks the replay flag one cycle later
  initial begin
    bit   pend_vld = 1'b0;
    bit   pend_exp = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (pend_vld) begin
          check("valid_ifill_resp", vld_resp, pend_exp);
          pend_vld = 1'b0;
        end else if (vld_resp) begin
          check("valid_ifill_resp_spurious", 1'b1, 1'b0);
        end
        if (strobe) begin
          if (exp_q.size() == 0) begin
            check("strobe_unexpected", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("line", line, e.line);
            check("way", way, e.way);
            check("addr", faddr, e.addr);
            check("latency", cyc - e.req_cyc, e.lat);
            pend_vld = 1'b1;
            pend_exp = e.vld;
          end
        end
        if (l2_req_valid) check("l2_req_paddr", l2_paddr, exp_req_addr);
        if (tout && !to_window) check("timeout_spurious", 1'b1, 1'b0);
      end
    end
  end

  // kmode: 0 clean, 1 kill in REQ, 2 kill with beat kbeat, 3 kill in RESP
  task automatic do_fill(input logic [PADDR_W-1:0] pa, input int kmode, input int kbeat,
                         input int rdly, input bit gaps);
    logic [BEAT_W-1:0] beats[NB];
    int                gap[NB];
    exp_t              e;
    int                lat;
    lat = 2 + NB + rdly;
    for (int i = 0; i < NB; i++) begin
      beats[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      gap[i]   = gaps ? $urandom_range(0, 2) : 0;
      lat     += gap[i];
      e.line[i*BEAT_W +: BEAT_W] = beats[i];
    end
    exp_req_addr = (pa / 64) * 64;
    req_valid = 1'b1;
    req_paddr = pa;
    if (kmode == 0 || kmode == 3) begin
      e.way     = N_WAY'(1) << (n_fills % N_WAY);
      e.addr    = exp_req_addr;
      e.vld     = (kmode == 0);
      e.lat     = lat;
      e.req_cyc = cyc;
      exp_q.push_back(e);
      n_fills++;
    end
    step();
    req_valid = 1'b0;
    check("ack_in_req", ack, 1'b1);
    for (int d = 0; d < rdly; d++) begin
      kill      = (kmode == 1 && d == 0);
      req_valid = $urandom_range(0, 1);
      req_paddr = {$urandom(), $urandom()};
      step();
    end
    req_valid = 1'b0;
    l2_ready  = 1'b1;
    kill      = (kmode == 1 && rdly == 0);
    step();
    l2_ready = 1'b0;
    kill     = 1'b0;
    for (int i = 0; i < NB; i++) begin
      for (int g = 0; g < gap[i]; g++) step();
      l2_rvalid = 1'b1;
      l2_rdata  = beats[i];
      kill      = (kmode == 2 && i == kbeat);
      step();
      l2_rvalid = 1'b0;
      kill      = 1'b0;
      l2_rdata  = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    check("ack_after_last_beat", ack, 1'b0);
    kill = (kmode == 3);
    step();
    kill = 1'b0;
    step();
  endtask

  task automatic stray_beat();
    l2_rvalid = 1'b1;
    l2_rdata  = {$urandom(), $urandom(), $urandom(), $urandom()};
    step();
    l2_rvalid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, ack, 1'b0);
    check({tag, "_strobe"}, strobe, 1'b0);
    check({tag, "_valid"}, vld_resp, 1'b0);
    check({tag, "_l2_req_valid"}, l2_req_valid, 1'b0);
    check({tag, "_line"}, line, '0);
    check({tag, "_way"}, way, '0);
    check({tag, "_addr"}, faddr, '0);
    check({tag, "_l2_paddr"}, l2_paddr, '0);
    check({tag, "_timeout"}, tout, 1'b0);
  endtask

  initial begin
    #(200000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    check_all_zero("reset");
    rstn = 1'b1;
    step();
    mon_en = 1'b1;
    check_all_zero("post_reset");

    // directed: basic fill, way rotation with wrap, kill variants
    do_fill(40'h80_0000_1234, 0, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) do_fill({$urandom(), $urandom()}, 0, 0, 0, 1'b0);
    do_fill({$urandom(), $urandom()}, 2, 1, 0, 1'b0);
    do_fill({$urandom(), $urandom()}, 1, 0, 5, 1'b0);
    do_fill({$urandom(), $urandom()}, 2, NB - 1, 0, 1'b0);
    do_fill({$urandom(), $urandom()}, 3, 0, 0, 1'b0);
    stray_beat();
    do_fill({$urandom(), $urandom()}, 0, 0, 1, 1'b1);

    // reset in the middle of WAIT, then stray beats must be ignored
    exp_req_addr = 40'h12_3456_7800;
    req_valid = 1'b1;
    req_paddr = 40'h12_3456_7812;
    step();
    req_valid = 1'b0;
    l2_ready  = 1'b1;
    step();
    l2_ready = 1'b0;
    stray_beat();
    stray_beat();
    rstn      = 1'b0;
    l2_rvalid = 1'b1;
    step();
    l2_rvalid = 1'b0;
    check_all_zero("mid_wait_reset");
    rstn = 1'b1;
    n_fills = 0;
    stray_beat();
    stray_beat();
    do_fill({$urandom(), $urandom()}, 0, 0, 0, 1'b0);

`ifdef ICACHE_IFILL_TIMEOUT_EN
    begin
      int c;
      int seen;
      exp_req_addr = 40'h00_0000_4000;
      req_valid = 1'b1;
      req_paddr = 40'h00_0000_4008;
      step();
      req_valid = 1'b0;
      l2_ready  = 1'b1;
      step();
      l2_ready  = 1'b0;
      to_window = 1'b1;
      c = cyc;
      stray_beat();
      seen = 0;
      for (int k = 0; k < 40 && seen == 0; k++) begin
        if (tout) seen = cyc - c;
        else step();
      end
      if (tout) seen = cyc - c;
      check("timeout_cycle", seen, 17);
      check("timeout_ack", ack, 1'b0);
      step();
      check("timeout_pulse_width", tout, 1'b0);
      to_window = 1'b0;
      for (int i = 0; i < NB; i++) stray_beat();
      do_fill({$urandom(), $urandom()}, 0, 0, 0, 1'b0);
    end
`endif

    // randomized fills with kills, ready delays and beat gaps
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) stray_beat();
      do_fill({$urandom(), $urandom()}, $urandom_range(0, 3), $urandom_range(0, NB - 1),
              $urandom_range(0, 3), 1'b1);
    end

    repeat (4) step();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
